memory_bus_arbiter: RTL and testbench



---
 rtl/memory_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_memory_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Two-requester (core/host) arbiter for a single memory port with a watchdog abort.
// Optional build macro HOST_PRIORITY_EN: host wins every tie instead of round-robin.
module memory_bus_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_read_memory,
  input  logic                 core_write_memory,
  input  logic [BUS_WIDTH-1:0] core_address_memory,
  input  logic [BUS_WIDTH-1:0] core_write_data_memory,
  output logic [BUS_WIDTH-1:0] core_read_data_memory,
  output logic                 core_memory_response,
  input  logic                 host_read_memory,
  input  logic                 host_write_memory,
  input  logic [BUS_WIDTH-1:0] host_address_memory,
  input  logic [BUS_WIDTH-1:0] host_write_data_memory,
  output logic [BUS_WIDTH-1:0] host_read_data_memory,
  output logic                 host_memory_response,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_write_data,
  input  logic [BUS_WIDTH-1:0] mem_read_data,
  input  logic                 mem_response,
  output logic                 grant_host,
  output logic                 timeout_error
);
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
  } req_t;

  state_t          state, state_nxt;
  req_t            core_req, host_req, win;
  logic            core_pend, host_pend, tie_host, grant_to_host;
  logic            grant, ack, abort;
  logic            owner_host, last_host;
  logic [WD_W-1:0] wd_cnt;

  assign core_req  = '{core_read_memory, core_write_memory, core_address_memory, core_write_data_memory};
  assign host_req  = '{host_read_memory, host_write_memory, host_address_memory, host_write_data_memory};
  assign core_pend = core_read_memory | core_write_memory;
  assign host_pend = host_read_memory | host_write_memory;

`ifdef HOST_PRIORITY_EN
  assign tie_host = 1'b1;
`else
  assign tie_host = ~last_host;
`endif

  assign grant_to_host = host_pend & (~core_pend | tie_host);
  assign win           = grant_to_host ? host_req : core_req;
  assign grant         = (state == IDLE) & (core_pend | host_pend);
  assign ack           = (state == BUSY) & mem_response;
  // A same-cycle acknowledge beats the watchdog.
  assign abort         = (TIMEOUT_CYCLES != 0) & (state == BUSY) & ~mem_response & (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_pend | host_pend) state_nxt = BUSY;
      BUSY:    if (ack | abort)           state_nxt = DONE;
      DONE:                               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_host            <= 1'b0;
      last_host             <= 1'b1;
      wd_cnt                <= '0;
      mem_read              <= 1'b0;
      mem_write             <= 1'b0;
      mem_address           <= '0;
      mem_write_data        <= '0;
      core_read_data_memory <= '0;
      host_read_data_memory <= '0;
      timeout_error         <= 1'b0;
    end else if (grant) begin
      owner_host     <= grant_to_host;
      last_host      <= grant_to_host;
      wd_cnt         <= '0;
      mem_write      <= win.wr;
      mem_read       <= win.rd & ~win.wr;
      mem_address    <= win.addr;
      mem_write_data <= win.wdata;
    end else if (state == BUSY) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (ack | abort) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (abort) begin
        timeout_error <= 1'b1;
        if (owner_host) host_read_data_memory <= '0;
        else            core_read_data_memory <= '0;
      end else if (ack && mem_read) begin
        if (owner_host) host_read_data_memory <= mem_read_data;
        else            core_read_data_memory <= mem_read_data;
      end
    end
  end

  assign core_memory_response = (state == DONE) & ~owner_host;
  assign host_memory_response = (state == DONE) &  owner_host;
  assign grant_host           = (state != IDLE) &  owner_host;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: stimulus pushes expected responses, a monitor pops them.
module tb_memory_bus_arbiter;
  localparam int W = 32;
  localparam int T = 8;

  logic clk = 1'b0;
  logic reset;
  logic core_read_memory, core_write_memory, host_read_memory, host_write_memory;
  logic [W-1:0] core_address_memory, core_write_data_memory, core_read_data_memory;
  logic [W-1:0] host_address_memory, host_write_data_memory, host_read_data_memory;
  logic core_memory_response, host_memory_response;
  logic mem_read, mem_write, mem_response, grant_host, timeout_error;
  logic [W-1:0] mem_address, mem_write_data, mem_read_data;

  memory_bus_arbiter #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .core_read_memory(core_read_memory), .core_write_memory(core_write_memory),
    .core_address_memory(core_address_memory), .core_write_data_memory(core_write_data_memory),
    .core_read_data_memory(core_read_data_memory), .core_memory_response(core_memory_response),
    .host_read_memory(host_read_memory), .host_write_memory(host_write_memory),
    .host_address_memory(host_address_memory), .host_write_data_memory(host_write_data_memory),
    .host_read_data_memory(host_read_data_memory), .host_memory_response(host_memory_response),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_response(mem_response),
    .grant_host(grant_host), .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           h;
    logic [W-1:0] core_rd;
    logic [W-1:0] host_rd;
  } exp_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] m_core_rd = '0;
  logic [W-1:0] m_host_rd = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (core_memory_response || host_memory_response) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response actual=core:%0b/host:%0b required=none",
                 core_memory_response, host_memory_response);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_host_resp", 32'(host_memory_response), 32'(e.h));
        check("sb_core_resp", 32'(core_memory_response), 32'(!e.h));
        check("sb_core_rdata", core_read_data_memory, e.core_rd);
        check("sb_host_rdata", host_read_data_memory, e.host_rd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit h, input bit rd, input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
    if (h) begin
      host_read_memory = rd; host_write_memory = wr;
      host_address_memory = a; host_write_data_memory = d;
    end else begin
      core_read_memory = rd; core_write_memory = wr;
      core_address_memory = a; core_write_data_memory = d;
    end
  endtask

  // Entered one step after the grant edge (first BUSY cycle); lat=0 means the memory never acks.
  // Returns one step into the IDLE cycle after DONE, with the owner's request dropped.
  task automatic serve(input bit h, input bit wr, input logic [W-1:0] a, input logic [W-1:0] d,
                       input int lat, input logic [W-1:0] rdat);
    exp_t e;
    check("grant_host", 32'(grant_host), 32'(h));
    check("mem_read", 32'(mem_read), 32'(!wr));
    check("mem_write", 32'(mem_write), 32'(wr));
    if (lat == 0) begin
      if (h) m_host_rd = '0; else m_core_rd = '0;
    end else if (!wr) begin
      if (h) m_host_rd = rdat; else m_core_rd = rdat;
    end
    e.h = h; e.core_rd = m_core_rd; e.host_rd = m_host_rd;
    sb.push_back(e);
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        check("mem_address_hold", mem_address, a);
        if (wr) check("mem_wdata_hold", mem_write_data, d);
        tick();
      end
      check("mem_address", mem_address, a);
      mem_response = 1'b1;
      mem_read_data = rdat;
      tick();
      mem_response = 1'b0;
      mem_read_data = 32'h0BAD_F00D;
    end else begin
      repeat (T - 1) tick();
      check("busy_before_abort", 32'(mem_read | mem_write), 32'd1);
      tick();
    end
    check("resp_pulse", 32'(h ? host_memory_response : core_memory_response), 32'd1);
    check("done_strobes", 32'(mem_read | mem_write), 32'd0);
    check("done_grant_host", 32'(grant_host), 32'(h));
    tick();
    req(h, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_rd"}, core_read_data_memory, '0);
    check({tag, "_host_rd"}, host_read_data_memory, '0);
    check({tag, "_mem_rw"}, 32'({mem_read, mem_write}), 32'd0);
    check({tag, "_mem_addr"}, mem_address, '0);
    check({tag, "_resp"}, 32'({core_memory_response, host_memory_response}), 32'd0);
    check({tag, "_grant_host"}, 32'(grant_host), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit first_host;
    reset = 1'b1;
    req(0, 0, 0, '0, '0);
    req(1, 0, 0, '0, '0);
    mem_response = 1'b0;
    mem_read_data = '0;
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Core read, ack three cycles after grant.
    req(0, 1, 0, 32'h100, '0);
    check("idle_no_strobe", 32'(mem_read), 32'd0);
    tick();
    serve(0, 0, 32'h100, '0, 3, 32'hCAFE_BABE);

    // Host write, then host read.
    req(1, 0, 1, 32'h20, 32'h1234_5678);
    tick();
    serve(1, 1, 32'h20, 32'h1234_5678, 2, 32'h0);
    req(1, 1, 0, 32'h44, '0);
    tick();
    serve(1, 0, 32'h44, '0, 1, 32'hDEAD_BEEF);

    // Ties: last grant is host here, so round-robin starts with core.
`ifdef HOST_PRIORITY_EN
    first_host = 1'b1;
`else
    first_host = 1'b0;
`endif
    for (int r = 0; r < 4; r++) begin
      req(0, 1, 0, 32'h400 + 32'(r), '0);
      req(1, 1, 0, 32'h800 + 32'(r), '0);
      tick();
      serve(first_host, 0, first_host ? 32'h800 + 32'(r) : 32'h400 + 32'(r), '0, 1,
            32'hA000_0000 + 32'(r));
      tick();
      serve(!first_host, 0, first_host ? 32'h400 + 32'(r) : 32'h800 + 32'(r), '0, 2,
            32'hB000_0000 + 32'(r));
    end

    // Read and write both high: only the write reaches memory.
    req(0, 1, 1, 32'h200, 32'hA5A5_A5A5);
    tick();
    check("rw_wdata", mem_write_data, 32'hA5A5_A5A5);
    serve(0, 1, 32'h200, 32'hA5A5_A5A5, 1, 32'h7777_7777);

    // Acknowledge outside BUSY is ignored.
    mem_response = 1'b1;
    mem_read_data = 32'hFFFF_FFFF;
    tick();
    mem_response = 1'b0;
    tick();
    check("stray_ack_core_rd", core_read_data_memory, m_core_rd);
    check("stray_ack_grant", 32'(grant_host), 32'd0);

    // Watchdog abort, then a good transaction keeps the sticky error.
    check("timeout_clear", 32'(timeout_error), 32'd0);
    req(0, 1, 0, 32'h300, '0);
    tick();
    serve(0, 0, 32'h300, '0, 0, '0);
    check("timeout_set", 32'(timeout_error), 32'd1);
    req(1, 1, 0, 32'h48, '0);
    tick();
    serve(1, 0, 32'h48, '0, 2, 32'h5151_5151);
    check("timeout_sticky", 32'(timeout_error), 32'd1);

    // Reset in BUSY: no pulse, everything cleared, next request works.
    req(0, 1, 0, 32'h500, '0);
    tick();
    check("pre_reset_busy", 32'(mem_read), 32'd1);
    reset = 1'b1;
    req(0, 0, 0, '0, '0);
    tick();
    m_core_rd = '0;
    m_host_rd = '0;
    check_all_zero("midreset");
    reset = 1'b0;
    tick();
    req(0, 1, 0, 32'h600, '0);
    tick();
    serve(0, 0, 32'h600, '0, 2, 32'h55AA_55AA);
    check("post_reset_core_rd", core_read_data_memory, 32'h55AA_55AA);

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
